// File: rtl/mc_exec_core.sv
// mc_exec_core
//   Execution core of the 8-bit / 12-bit-instruction microcontroller.
//   The block has three parts:
//     - a control decoder driven by the stage counter and IR
//     - an 8-bit ALU with its operand-2 select
//     - a 16x8 data memory, which is the only state in the block
//   The parent holds PC/Acc/SR/DR/IR, program memory and the stage counter.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   stage[1:0]          00 LOAD, 01 FETCH, 10 DECODE, 11 EXECUTE
//   ir[11:0]            current instruction
//   acc[7:0]            accumulator (ALU operand 1)
//   sr[3:0]             status flags {Z,C,S,O}
//   dr[7:0]             data register (operand 2 for M-type)
//   pc_e .. dr_e        register load enables
//   pmem_e, pmem_le     program memory enable / load enable
//   mux1_sel            PC source: 1 = PC+1, 0 = ir[7:0]
//   dmem_e, dmem_we     data memory enable / write enable
//   alu_out[7:0]        ALU result (0 while the ALU is idle)
//   sr_new[3:0]         ALU flags (equal to sr while the ALU is idle)
//   dmem_rdata[7:0]     mem[ir[3:0]], combinational read
//
// Build option
//   ALU_ROTATE_EN       defined: modes A/B rotate operand 2 by acc[2:0].
//                       undefined: modes A/B behave as MOVB, no rotator.
//
// stage | meaning
// ------+-----------------------------------------------------------
// LOAD  | program memory being loaded (pmem_le, pmem_e)
// FETCH | instruction read into IR (ir_e, pmem_e)
// DECODE| M-type: data memory word latched into DR
// EXEC  | ALU op / jump / store, PC advanced

module mc_exec_core #(
   parameter int DATA_W  = 8,
   parameter int DMEM_AW = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        stage,
   input  logic [11:0]       ir,
   input  logic [DATA_W-1:0] acc,
   input  logic [3:0]        sr,
   input  logic [DATA_W-1:0] dr,
   output logic              pc_e,
   output logic              acc_e,
   output logic              sr_e,
   output logic              ir_e,
   output logic              dr_e,
   output logic              pmem_e,
   output logic              pmem_le,
   output logic              mux1_sel,
   output logic              dmem_e,
   output logic              dmem_we,
   output logic [DATA_W-1:0] alu_out,
   output logic [3:0]        sr_new,
   output logic [DATA_W-1:0] dmem_rdata
);

   localparam int DMEM_D = 1 << DMEM_AW;

   localparam logic [1:0] STG_LOAD   = 2'b00;
   localparam logic [1:0] STG_FETCH  = 2'b01;
   localparam logic [1:0] STG_DECODE = 2'b10;
   localparam logic [1:0] STG_EXEC   = 2'b11;

   logic              alu_e;
   logic [3:0]        alu_mode;
   logic [DATA_W-1:0] op2;

   // ---------------------------------------------------------------
   // Control decode
   // ---------------------------------------------------------------
   always_comb begin
      pc_e     = 1'b0;
      acc_e    = 1'b0;
      sr_e     = 1'b0;
      ir_e     = 1'b0;
      dr_e     = 1'b0;
      pmem_e   = 1'b0;
      pmem_le  = 1'b0;
      mux1_sel = 1'b0;
      dmem_e   = 1'b0;
      dmem_we  = 1'b0;
      alu_e    = 1'b0;
      alu_mode = 4'h0;
      op2      = '0;
      if (!rst) begin
         case (stage)
            STG_LOAD: begin
               pmem_le = 1'b1;
               pmem_e  = 1'b1;
            end
            STG_FETCH: begin
               ir_e   = 1'b1;
               pmem_e = 1'b1;
            end
            STG_DECODE: begin
               if (ir[11:9] == 3'b001) begin
                  dr_e   = 1'b1;
                  dmem_e = 1'b1;
               end
            end
            STG_EXEC: begin
               if (ir[11]) begin
                  // I-type: immediate operand, only modes 0-7 reachable
                  alu_e    = 1'b1;
                  acc_e    = 1'b1;
                  sr_e     = 1'b1;
                  pc_e     = 1'b1;
                  alu_mode = {1'b0, ir[10:8]};
                  op2      = ir[DATA_W-1:0];
                  mux1_sel = 1'b1;
               end else if (ir[10]) begin
                  // Conditional jump: flag index 0=O,1=S,2=C,3=Z; set flag jumps
                  pc_e     = 1'b1;
                  mux1_sel = ~sr[ir[9:8]];
               end else if (ir[9]) begin
                  // M-type: operand from DR, result to Acc (ir[8]) or memory
                  alu_e    = 1'b1;
                  sr_e     = 1'b1;
                  pc_e     = 1'b1;
                  alu_mode = ir[7:4];
                  op2      = dr;
                  mux1_sel = 1'b1;
                  if (ir[8]) begin
                     acc_e = 1'b1;
                  end else begin
                     dmem_e  = 1'b1;
                     dmem_we = 1'b1;
                  end
               end else begin
                  // ir[8]=0 NOP (PC+1), ir[8]=1 JMP (ir[7:0])
                  pc_e     = 1'b1;
                  mux1_sel = ~ir[8];
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // ALU
   // ---------------------------------------------------------------
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] res;
   logic              c_flag;
   logic              o_flag;
`ifdef ALU_ROTATE_EN
   logic [2*DATA_W-1:0] rot_w;
`endif

   always_comb begin
      sum    = '0;
      res    = '0;
      c_flag = sr[2];
      o_flag = sr[0];
`ifdef ALU_ROTATE_EN
      rot_w  = '0;
`endif
      case (alu_mode)
         4'h0: begin
            sum    = {1'b0, acc} + {1'b0, op2};
            res    = sum[DATA_W-1:0];
            c_flag = sum[DATA_W];
            o_flag = (acc[DATA_W-1] == op2[DATA_W-1]) && (res[DATA_W-1] != acc[DATA_W-1]);
         end
         4'h1: begin
            sum    = {1'b0, acc} - {1'b0, op2};
            res    = sum[DATA_W-1:0];
            c_flag = sum[DATA_W];
            o_flag = (acc[DATA_W-1] != op2[DATA_W-1]) && (res[DATA_W-1] != acc[DATA_W-1]);
         end
         4'h2: res = acc;
         4'h3: res = op2;
         4'h4: res = acc & op2;
         4'h5: res = acc | op2;
         4'h6: res = acc ^ op2;
         4'h7: begin
            sum    = {1'b0, op2} - {1'b0, acc};
            res    = sum[DATA_W-1:0];
            c_flag = sum[DATA_W];
            o_flag = (op2[DATA_W-1] != acc[DATA_W-1]) && (res[DATA_W-1] != op2[DATA_W-1]);
         end
         4'h8: begin
            sum    = {1'b0, op2} + 1'b1;
            res    = sum[DATA_W-1:0];
            c_flag = sum[DATA_W];
            o_flag = ~op2[DATA_W-1] & res[DATA_W-1];
         end
         4'h9: begin
            sum    = {1'b0, op2} - 1'b1;
            res    = sum[DATA_W-1:0];
            c_flag = sum[DATA_W];
            o_flag = op2[DATA_W-1] & ~res[DATA_W-1];
         end
`ifdef ALU_ROTATE_EN
         // Doubling the operand turns a rotate into a plain shift window
         4'hA: begin
            rot_w = {op2, op2} << acc[2:0];
            res   = rot_w[2*DATA_W-1:DATA_W];
         end
         4'hB: begin
            rot_w = {op2, op2} >> acc[2:0];
            res   = rot_w[DATA_W-1:0];
         end
`else
         4'hA, 4'hB: res = op2;
`endif
         4'hC: begin
            res    = {op2[DATA_W-2:0], 1'b0};
            c_flag = op2[DATA_W-1];
         end
         4'hD: begin
            res    = {1'b0, op2[DATA_W-1:1]};
            c_flag = op2[0];
         end
         4'hE: res = ~op2;
         4'hF: begin
            sum    = {(DATA_W+1){1'b0}} - {1'b0, op2};
            res    = sum[DATA_W-1:0];
            c_flag = sum[DATA_W];
            o_flag = op2[DATA_W-1] & res[DATA_W-1];
         end
         default: ;
      endcase
   end

   assign alu_out = alu_e ? res : '0;
   assign sr_new  = alu_e ? {(res == '0), c_flag, res[DATA_W-1], o_flag} : sr;

   // ---------------------------------------------------------------
   // Data memory
   // ---------------------------------------------------------------
   logic [DATA_W-1:0] mem_q [DMEM_D];
   logic [DATA_W-1:0] mem_d [DMEM_D];

   always_comb begin
      mem_d = mem_q;
      if (dmem_we) begin
         mem_d[ir[DMEM_AW-1:0]] = alu_out;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DMEM_D; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign dmem_rdata = mem_q[ir[DMEM_AW-1:0]];

endmodule

// File: tb/tb_mc_exec_core.sv
module tb_mc_exec_core;

   localparam logic [1:0] S_LOAD = 2'b00;
   localparam logic [1:0] S_FETCH = 2'b01;
   localparam logic [1:0] S_DEC = 2'b10;
   localparam logic [1:0] S_EXEC = 2'b11;

   // enable bundle: {pc,acc,sr,ir,dr,pmem_e,pmem_le,mux1_sel,dmem_e,dmem_we}
   localparam logic [9:0] EN_NONE   = 10'b0000000000;
   localparam logic [9:0] EN_LOAD   = 10'b0000011000;
   localparam logic [9:0] EN_FETCH  = 10'b0001010000;
   localparam logic [9:0] EN_DEC_M  = 10'b0000100010;
   localparam logic [9:0] EN_ALU_A  = 10'b1110000100;
   localparam logic [9:0] EN_STORE  = 10'b1010000111;

`ifdef ALU_ROTATE_EN
   localparam logic [7:0] ROL_R = 8'h03;
   localparam logic [3:0] ROL_F = 4'b0101;
   localparam logic [7:0] ROR_R = 8'h20;
`else
   localparam logic [7:0] ROL_R = 8'h81;
   localparam logic [3:0] ROL_F = 4'b0111;
   localparam logic [7:0] ROR_R = 8'h01;
`endif

   typedef struct packed {
      logic [3:0] mode;
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] f;
      logic [7:0] r;
      logic [3:0] fo;
   } alu_vec_t;

   localparam int N_ALU = 22;
   localparam alu_vec_t ALU_TBL [N_ALU] = '{
      '{4'h0, 8'h80, 8'h80, 4'b0000, 8'h00, 4'b1101},
      '{4'h0, 8'h7F, 8'h01, 4'b0000, 8'h80, 4'b0011},
      '{4'h1, 8'h05, 8'h07, 4'b0000, 8'hFE, 4'b0110},
      '{4'h1, 8'h80, 8'h01, 4'b0000, 8'h7F, 4'b0001},
      '{4'h2, 8'hA5, 8'h00, 4'b0101, 8'hA5, 4'b0111},
      '{4'h3, 8'h11, 8'h00, 4'b0000, 8'h00, 4'b1000},
      '{4'h4, 8'hF0, 8'h3C, 4'b0100, 8'h30, 4'b0100},
      '{4'h5, 8'hF0, 8'h0C, 4'b0000, 8'hFC, 4'b0010},
      '{4'h6, 8'hFF, 8'h0F, 4'b0000, 8'hF0, 4'b0010},
      '{4'h7, 8'h03, 8'h01, 4'b0000, 8'hFE, 4'b0110},
      '{4'h8, 8'h00, 8'h7F, 4'b0000, 8'h80, 4'b0011},
      '{4'h8, 8'h00, 8'hFF, 4'b0000, 8'h00, 4'b1100},
      '{4'h9, 8'h00, 8'h00, 4'b0000, 8'hFF, 4'b0110},
      '{4'h9, 8'h00, 8'h80, 4'b0000, 8'h7F, 4'b0001},
      '{4'hC, 8'h00, 8'h81, 4'b0001, 8'h02, 4'b0101},
      '{4'hD, 8'h00, 8'h81, 4'b0000, 8'h40, 4'b0100},
      '{4'hE, 8'h00, 8'h0F, 4'b0100, 8'hF0, 4'b0110},
      '{4'hF, 8'h00, 8'h01, 4'b0000, 8'hFF, 4'b0110},
      '{4'hF, 8'h00, 8'h80, 4'b0000, 8'h80, 4'b0111},
      '{4'hF, 8'h00, 8'h00, 4'b0000, 8'h00, 4'b1000},
      '{4'hA, 8'h01, 8'h81, 4'b0101, ROL_R, ROL_F},
      '{4'hB, 8'h03, 8'h01, 4'b0000, ROR_R, 4'b0000}
   };

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] stage;
   logic [11:0] ir;
   logic [7:0] acc, dr;
   logic [3:0] sr;
   logic pc_e, acc_e, sr_e, ir_e, dr_e, pmem_e, pmem_le, mux1_sel, dmem_e, dmem_we;
   logic [7:0] alu_out, dmem_rdata;
   logic [3:0] sr_new;
   logic [9:0] en;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign en = {pc_e, acc_e, sr_e, ir_e, dr_e, pmem_e, pmem_le, mux1_sel, dmem_e, dmem_we};

   mc_exec_core dut (
      .clk(clk), .rst(rst), .stage(stage), .ir(ir), .acc(acc), .sr(sr), .dr(dr),
      .pc_e(pc_e), .acc_e(acc_e), .sr_e(sr_e), .ir_e(ir_e), .dr_e(dr_e),
      .pmem_e(pmem_e), .pmem_le(pmem_le), .mux1_sel(mux1_sel),
      .dmem_e(dmem_e), .dmem_we(dmem_we), .alu_out(alu_out), .sr_new(sr_new),
      .dmem_rdata(dmem_rdata)
   );

   // Inputs change on even times; rising edges fall on 5+10k, so no
   // combinational sample coincides with an edge.
   task automatic drive(input logic [1:0] s, input logic [11:0] i,
                        input logic [7:0] a, input logic [7:0] d, input logic [3:0] f);
      stage = s; ir = i; acc = a; dr = d; sr = f;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [1:0] s;
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         s = 2'(k);
         drive(s, 12'h213, 8'h10, 8'h10, 4'hF);
         n_vec++;
         if ((en & 10'b1111111011) !== EN_NONE) begin
            $display("FAIL reset_en stage=%0d got %b exp %b", k, en & 10'b1111111011, EN_NONE);
            n_err++;
         end
      end
      tick();
      tick();
      rst = 1'b0;
      for (int k = 0; k < 16; k++) begin
         drive(S_DEC, 12'h200 | 12'(k), 8'h00, 8'h00, 4'h0);
         n_vec++;
         if (dmem_rdata !== 8'h00) begin
            $display("FAIL reset_mem addr=%0d got %h exp 00", k, dmem_rdata);
            n_err++;
         end
      end
   endtask

   task automatic test_stages();
      drive(S_LOAD, 12'h805, 8'h00, 8'h00, 4'h0);
      n_vec++;
      if (en !== EN_LOAD) begin
         $display("FAIL load_en got %b exp %b", en, EN_LOAD); n_err++;
      end
      drive(S_FETCH, 12'h313, 8'h00, 8'h00, 4'h0);
      n_vec++;
      if (en !== EN_FETCH) begin
         $display("FAIL fetch_en got %b exp %b", en, EN_FETCH); n_err++;
      end
      drive(S_DEC, 12'h313, 8'h00, 8'h00, 4'h0);
      n_vec++;
      if (en !== EN_DEC_M) begin
         $display("FAIL decode_m_en got %b exp %b", en, EN_DEC_M); n_err++;
      end
      drive(S_DEC, 12'h805, 8'h00, 8'h00, 4'h0);
      n_vec++;
      if (en !== EN_NONE) begin
         $display("FAIL decode_i_en got %b exp %b", en, EN_NONE); n_err++;
      end
   endtask

   task automatic test_itype();
      logic [11:0] iv [4] = '{12'h805, 12'h801, 12'hE0F, 12'hF05};
      logic [7:0]  av [4] = '{8'hFE, 8'h7F, 8'hFF, 8'h03};
      logic [7:0]  rv [4] = '{8'h03, 8'h80, 8'hF0, 8'h02};
      logic [3:0]  fv [4] = '{4'b0100, 4'b0011, 4'b0010, 4'b0000};
      for (int k = 0; k < 4; k++) begin
         drive(S_EXEC, iv[k], av[k], 8'h99, 4'h0);
         n_vec++;
         if (alu_out !== rv[k] || sr_new !== fv[k] || en !== EN_ALU_A) begin
            $display("FAIL itype ir=%h got out=%h sr=%b en=%b exp out=%h sr=%b en=%b",
                     iv[k], alu_out, sr_new, en, rv[k], fv[k], EN_ALU_A);
            n_err++;
         end
      end
   endtask

   task automatic test_alu_ops();
      alu_vec_t v;
      for (int k = 0; k < N_ALU; k++) begin
         v = ALU_TBL[k];
         drive(S_EXEC, {4'b0011, v.mode, 4'h0}, v.a, v.b, v.f);
         n_vec++;
         if (alu_out !== v.r || sr_new !== v.fo || en !== EN_ALU_A) begin
            $display("FAIL alu_op mode=%h a=%h b=%h got out=%h sr=%b en=%b exp out=%h sr=%b en=%b",
                     v.mode, v.a, v.b, alu_out, sr_new, en, v.r, v.fo, EN_ALU_A);
            n_err++;
         end
      end
   endtask

   task automatic test_alu_idle();
      drive(S_FETCH, 12'h805, 8'hFE, 8'h00, 4'b1011);
      n_vec++;
      if (alu_out !== 8'h00 || sr_new !== 4'b1011) begin
         $display("FAIL alu_idle_fetch got out=%h sr=%b exp out=00 sr=1011", alu_out, sr_new);
         n_err++;
      end
      drive(S_EXEC, 12'h742, 8'hFE, 8'h01, 4'b0110);
      n_vec++;
      if (alu_out !== 8'h00 || sr_new !== 4'b0110) begin
         $display("FAIL alu_idle_jump got out=%h sr=%b exp out=00 sr=0110", alu_out, sr_new);
         n_err++;
      end
   endtask

   task automatic test_jumps();
      logic [11:0] iv [9] = '{12'h742, 12'h742, 12'h455, 12'h455, 12'h555,
                              12'h655, 12'h655, 12'h155, 12'h000};
      logic [3:0]  fv [9] = '{4'b1000, 4'b0000, 4'b0001, 4'b1110, 4'b0010,
                              4'b0100, 4'b1011, 4'b1111, 4'b1111};
      logic        mv [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [9:0]  exp_en;
      for (int k = 0; k < 9; k++) begin
         drive(S_EXEC, iv[k], 8'h00, 8'h00, fv[k]);
         exp_en = {1'b1, 6'b000000, mv[k], 2'b00};
         n_vec++;
         if (en !== exp_en) begin
            $display("FAIL jump ir=%h sr=%b got en=%b exp en=%b", iv[k], fv[k], en, exp_en);
            n_err++;
         end
      end
   endtask

   task automatic test_store();
      // ADD 0x12+0x34 stored at addr 3; old value visible until the edge
      drive(S_EXEC, 12'h203, 8'h12, 8'h34, 4'h0);
      n_vec++;
      if (en !== EN_STORE || alu_out !== 8'h46 || dmem_rdata !== 8'h00) begin
         $display("FAIL store_add got en=%b out=%h rd=%h exp en=%b out=46 rd=00",
                  en, alu_out, dmem_rdata, EN_STORE);
         n_err++;
      end
      tick();
      drive(S_DEC, 12'h203, 8'h00, 8'h00, 4'h0);
      n_vec++;
      if (dmem_rdata !== 8'h46) begin
         $display("FAIL store_add_rd got %h exp 46", dmem_rdata); n_err++;
      end
      // Acc-destination M-type must not write memory
      drive(S_EXEC, 12'h313, 8'h10, 8'h10, 4'h0);
      n_vec++;
      if (en !== EN_ALU_A || alu_out !== 8'h00 || sr_new !== 4'b1000) begin
         $display("FAIL macc got en=%b out=%h sr=%b exp en=%b out=00 sr=1000",
                  en, alu_out, sr_new, EN_ALU_A);
         n_err++;
      end
      tick();
      drive(S_DEC, 12'h203, 8'h00, 8'h00, 4'h0);
      n_vec++;
      if (dmem_rdata !== 8'h46) begin
         $display("FAIL macc_nowrite got %h exp 46", dmem_rdata); n_err++;
      end
      drive(S_EXEC, 12'h213, 8'h10, 8'h10, 4'h0);
      n_vec++;
      if (en !== EN_STORE || alu_out !== 8'h00 || sr_new !== 4'b1000) begin
         $display("FAIL store_sub got en=%b out=%h sr=%b exp en=%b out=00 sr=1000",
                  en, alu_out, sr_new, EN_STORE);
         n_err++;
      end
      tick();
      drive(S_DEC, 12'h203, 8'h00, 8'h00, 4'h0);
      n_vec++;
      if (dmem_rdata !== 8'h00) begin
         $display("FAIL store_sub_rd got %h exp 00", dmem_rdata); n_err++;
      end
   endtask

   task automatic test_mem_all();
      logic [7:0] val;
      for (int k = 0; k < 16; k++) begin
         val = 8'(k * 37 + 11);
         drive(S_EXEC, 12'h230 | 12'(k), 8'h00, val, 4'h0);
         tick();
      end
      for (int k = 0; k < 16; k++) begin
         val = 8'(k * 37 + 11);
         drive(S_DEC, 12'h200 | 12'(k), 8'h00, 8'h00, 4'h0);
         n_vec++;
         if (dmem_rdata !== val) begin
            $display("FAIL mem_rd addr=%0d got %h exp %h", k, dmem_rdata, val); n_err++;
         end
      end
   endtask

   task automatic test_clear_beats_write();
      rst = 1'b1;
      drive(S_EXEC, 12'h235, 8'h00, 8'h55, 4'h0);
      tick();
      rst = 1'b0;
      drive(S_LOAD, 12'h000, 8'h00, 8'h00, 4'h0);
      for (int k = 0; k < 16; k++) begin
         drive(S_DEC, 12'h200 | 12'(k), 8'h00, 8'h00, 4'h0);
         n_vec++;
         if (dmem_rdata !== 8'h00) begin
            $display("FAIL clear_mem addr=%0d got %h exp 00", k, dmem_rdata); n_err++;
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      stage = S_LOAD; ir = 12'h000; acc = 8'h00; dr = 8'h00; sr = 4'h0;
      tick();
      test_reset();
      test_stages();
      test_itype();
      test_alu_ops();
      test_alu_idle();
      test_jumps();
      test_store();
      test_mem_all();
      test_clear_beats_write();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
